// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: bus register map, bus direction
// encoding and FSM state encodings.
package irq_ctrl_pkg;

    typedef logic [3:0] irq_addr_t;

    localparam irq_addr_t IRQ_PEND_ADDR = 4'd0;
    localparam irq_addr_t IRQ_MASK_ADDR = 4'd1;
    localparam irq_addr_t IRQ_EDGE_ADDR = 4'd2;
    localparam irq_addr_t IRQ_CTRL_ADDR = 4'd3;
    localparam irq_addr_t IRQ_VEC_ADDR  = 4'd4;
    localparam irq_addr_t IRQ_ACK_ADDR  = 4'd5;

    // Irq_rw encoding shared with the Timer bus
    localparam logic IRQ_READ  = 1'b1;
    localparam logic IRQ_WRITE = 1'b0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational fixed-priority encoder: the lowest-index set request wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);

    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        // Descending scan so the last hit, the lowest index, is what remains
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: captures source lines into a pending register, prioritises
// the masked requests and holds one source in service until the CPU acknowledges it.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               Irq_cs,
    input  logic               Irq_as,
    input  logic               Irq_rw,
    input  logic [3:0]         Irq_addr,
    input  logic [31:0]        Irq_wr_data,
    output logic               Irq_rdy,
    output logic [31:0]        Irq_rd_data,
    output logic               cpu_irq,
    output logic [ID_W-1:0]    cpu_irq_id
);

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge_sel;
    logic [NUM_IRQ-1:0] r_prev_in;
    logic               r_enable;
    logic [0:0]         r_state;

    logic               w_bus;
    logic               w_wr;
    logic               w_rd;
    logic               w_ack;
    logic               w_grant;
    logic               w_valid;
    logic [ID_W-1:0]    w_id;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_req;
    logic [NUM_IRQ-1:0] w_grant_clr;
    logic [31:0]        w_rd_val;

    assign w_bus = Irq_cs & Irq_as;
    assign w_wr  = w_bus & (Irq_rw == IRQ_WRITE);
    assign w_rd  = w_bus & (Irq_rw == IRQ_READ);

    assign w_set = (r_edge_sel & irq_in & ~r_prev_in) | (~r_edge_sel & irq_in);
    assign w_w1c = (w_wr && Irq_addr == IRQ_PEND_ADDR) ? Irq_wr_data[NUM_IRQ-1:0] : '0;
    assign w_req = r_pending & r_mask & {NUM_IRQ{r_enable}};

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .i_req   (w_req),
        .o_valid (w_valid),
        .o_id    (w_id)
    );

    assign w_grant     = (r_state == ST_IDLE) && w_valid;
    assign w_grant_clr = w_grant ? (NUM_IRQ'(1) << w_id) : '0;
    // Only an exact, zero-extended match of the in-service ID ends service
    assign w_ack       = w_wr && (Irq_addr == IRQ_ACK_ADDR) && (Irq_wr_data == 32'(cpu_irq_id));

    always_comb begin
        w_rd_val = '0;
        case (Irq_addr)
            IRQ_PEND_ADDR: w_rd_val[NUM_IRQ-1:0] = r_pending;
            IRQ_MASK_ADDR: w_rd_val[NUM_IRQ-1:0] = r_mask;
            IRQ_EDGE_ADDR: w_rd_val[NUM_IRQ-1:0] = r_edge_sel;
            IRQ_CTRL_ADDR: w_rd_val[0]           = r_enable;
            IRQ_VEC_ADDR: begin
                w_rd_val[31]       = (r_state == ST_SERVE);
                w_rd_val[ID_W-1:0] = cpu_irq_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_pending   <= '0;
            r_mask      <= '0;
            r_edge_sel  <= '0;
            r_prev_in   <= '0;
            r_enable    <= 1'b0;
            r_state     <= ST_IDLE;
            Irq_rdy     <= 1'b0;
            Irq_rd_data <= '0;
            cpu_irq     <= 1'b0;
            cpu_irq_id  <= '0;
        end else begin
            r_prev_in <= irq_in;
            // New captures win over both software W1C and the grant clear
            r_pending <= (r_pending & ~w_w1c & ~w_grant_clr) | w_set;
            Irq_rdy   <= w_bus;
            if (w_rd) begin
                Irq_rd_data <= w_rd_val;
            end
            if (w_wr) begin
                case (Irq_addr)
                    IRQ_MASK_ADDR: r_mask     <= Irq_wr_data[NUM_IRQ-1:0];
                    IRQ_EDGE_ADDR: r_edge_sel <= Irq_wr_data[NUM_IRQ-1:0];
                    IRQ_CTRL_ADDR: r_enable   <= Irq_wr_data[0];
                    default: ;
                endcase
            end
            if (r_state == ST_IDLE) begin
                if (w_valid) begin
                    r_state    <= ST_SERVE;
                    cpu_irq    <= 1'b1;
                    cpu_irq_id <= w_id;
                end
            end else if (w_ack) begin
                r_state <= ST_IDLE;
                cpu_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed bus/IRQ scenarios, a cycle-level behavioural model
// compared every cycle, and hand-computed literal expectations.
module tb_irq_ctrl;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    logic               clk = 1'b0;
    logic               rest = 1'b1;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic               cs = 1'b0;
    logic               as = 1'b0;
    logic               rw = 1'b1;
    logic [3:0]         addr = '0;
    logic [31:0]        wr_data = '0;
    logic               Irq_rdy;
    logic [31:0]        Irq_rd_data;
    logic               cpu_irq;
    logic [ID_W-1:0]    cpu_irq_id;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rest        (rest),
        .irq_in      (irq_in),
        .Irq_cs      (cs),
        .Irq_as      (as),
        .Irq_rw      (rw),
        .Irq_addr    (addr),
        .Irq_wr_data (wr_data),
        .Irq_rdy     (Irq_rdy),
        .Irq_rd_data (Irq_rd_data),
        .cpu_irq     (cpu_irq),
        .cpu_irq_id  (cpu_irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model state
    logic [7:0]  m_pend = '0, m_mask = '0, m_edge = '0, m_prev = '0;
    logic [7:0]  m_clr = '0, m_new = '0;
    logic        m_en = 1'b0, m_serv = 1'b0, m_rdy = 1'b0, m_rd_chk = 1'b0;
    logic        m_bus = 1'b0, m_wr = 1'b0, m_found = 1'b0;
    logic [2:0]  m_id = '0;
    logic [31:0] m_rd = '0;
    int          m_win = 0;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd0:    return {24'd0, m_pend};
            4'd1:    return {24'd0, m_mask};
            4'd2:    return {24'd0, m_edge};
            4'd3:    return {31'd0, m_en};
            4'd4:    return {m_serv, 28'd0, m_id};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rest) begin
        if (rest) begin
            m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0; m_en = 1'b0;
            m_serv = 1'b0; m_id = '0; m_rdy = 1'b0; m_rd = '0; m_rd_chk = 1'b0;
        end else begin
            m_bus    = cs & as;
            m_wr     = m_bus & (rw == WR);
            m_rd_chk = m_bus & (rw == RD);
            if (m_rd_chk) m_rd = m_read(addr);
            m_rdy = m_bus;
            m_clr = (m_wr && addr == 4'd0) ? wr_data[7:0] : 8'd0;
            m_new = '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (irq_in[i] && (!m_edge[i] || !m_prev[i])) m_new[i] = 1'b1;
            end
            if (!m_serv) begin
                m_found = 1'b0;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (!m_found && m_en && m_pend[i] && m_mask[i]) begin
                        m_found = 1'b1;
                        m_win   = i;
                    end
                end
                if (m_found) begin
                    m_clr[m_win] = 1'b1;
                    m_serv = 1'b1;
                    m_id   = m_win[2:0];
                end
            end else if (m_wr && addr == 4'd5 && wr_data == {29'd0, m_id}) begin
                m_serv = 1'b0;
            end
            m_pend = (m_pend & ~m_clr) | m_new;
            if (m_wr && addr == 4'd1) m_mask = wr_data[7:0];
            if (m_wr && addr == 4'd2) m_edge = wr_data[7:0];
            if (m_wr && addr == 4'd3) m_en   = wr_data[0];
            m_prev = irq_in;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rest) begin
                chk("model_cpu_irq", {31'd0, cpu_irq}, {31'd0, m_serv});
                chk("model_cpu_irq_id", {29'd0, cpu_irq_id}, {29'd0, m_id});
                chk("model_rdy", {31'd0, Irq_rdy}, {31'd0, m_rdy});
                if (m_rd_chk) chk("model_rd_data", Irq_rd_data, m_rd);
            end
        end
    end

    // Bus tasks are entered on a falling edge and return on the next one
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        cs = 1'b1; as = 1'b1; rw = WR; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; as = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        cs = 1'b1; as = 1'b1; rw = RD; addr = a;
        @(negedge clk);
        cs = 1'b0; as = 1'b0;
        d = Irq_rd_data;
    endtask

    logic [31:0] v;

    initial begin
        rest = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
        chk("rst_cpu_irq_id", {29'd0, cpu_irq_id}, 32'd0);
        chk("rst_rdy", {31'd0, Irq_rdy}, 32'd0);
        chk("rst_rd_data", Irq_rd_data, 32'd0);
        rest = 1'b0;
        @(negedge clk);

        // Upper register bits ignore writes; unmapped reads are zero
        bus_wr(4'd1, 32'hFFFF_FFFF);
        bus_rd(4'd1, v); chk("mask_width", v, 32'h0000_00FF);
        bus_wr(4'd2, 32'h0000_00FF);
        bus_wr(4'd1, 32'h0000_0001);
        bus_rd(4'd9, v); chk("unmapped_rd", v, 32'd0);

        // Global enable off: pending latches but no request
        irq_in = 8'h01; @(negedge clk); irq_in = 8'h00; @(negedge clk);
        @(negedge clk);
        chk("gated_no_irq", {31'd0, cpu_irq}, 32'd0);
        bus_rd(4'd0, v); chk("gated_pend", v, 32'h0000_0001);
        bus_wr(4'd3, 32'd1);
        @(negedge clk);
        chk("enable_fires", {31'd0, cpu_irq}, 32'd1);
        bus_wr(4'd5, 32'd0);
        chk("ack0_drop", {31'd0, cpu_irq}, 32'd0);

        // Timer pulse, edge mode
        irq_in = 8'h01; @(negedge clk); irq_in = 8'h00; @(negedge clk);
        chk("t1_irq", {31'd0, cpu_irq}, 32'd1);
        bus_rd(4'd4, v); chk("t1_vec", v, 32'h8000_0000);
        bus_wr(4'd5, 32'd0);
        chk("t1_ack", {31'd0, cpu_irq}, 32'd0);

        // Simultaneous sources 5 and 2
        bus_wr(4'd1, 32'h24);
        irq_in = 8'h24; @(negedge clk); irq_in = 8'h00; @(negedge clk);
        chk("t2_first_irq", {31'd0, cpu_irq}, 32'd1);
        chk("t2_first_id", {29'd0, cpu_irq_id}, 32'd2);
        bus_wr(4'd5, 32'd2);
        chk("t2_gap", {31'd0, cpu_irq}, 32'd0);
        @(negedge clk);
        chk("t2_second_irq", {31'd0, cpu_irq}, 32'd1);
        chk("t2_second_id", {29'd0, cpu_irq_id}, 32'd5);
        bus_wr(4'd5, 32'd5);
        chk("t2_ack5", {31'd0, cpu_irq}, 32'd0);

        // Wrong ACK ignored; masking during service does not abort
        bus_wr(4'd1, 32'h08);
        irq_in = 8'h08; @(negedge clk); irq_in = 8'h00; @(negedge clk);
        chk("t3_id", {29'd0, cpu_irq_id}, 32'd3);
        bus_wr(4'd1, 32'h00);
        chk("t3_mask_no_abort", {31'd0, cpu_irq}, 32'd1);
        bus_wr(4'd5, 32'd4);
        chk("t3_wrong_ack", {31'd0, cpu_irq}, 32'd1);
        bus_wr(4'd5, 32'd3);
        chk("t3_ack", {31'd0, cpu_irq}, 32'd0);

        // Set beats W1C on the same bit
        irq_in = 8'h02; @(negedge clk); irq_in = 8'h00; @(negedge clk);
        bus_rd(4'd0, v); chk("t4_pend_before", v, 32'h02);
        irq_in = 8'h02;
        bus_wr(4'd0, 32'h02);
        irq_in = 8'h00;
        bus_rd(4'd0, v); chk("t4_set_wins", v, 32'h02);
        bus_wr(4'd0, 32'h02);
        bus_rd(4'd0, v); chk("t4_w1c", v, 32'h00);

        // Level source re-pends after W1C
        bus_wr(4'd2, 32'h00);
        irq_in = 8'h10; @(negedge clk); @(negedge clk);
        bus_wr(4'd0, 32'h10);
        bus_rd(4'd0, v); chk("t5_repend", v, 32'h10);
        chk("t5_masked", {31'd0, cpu_irq}, 32'd0);
        bus_wr(4'd1, 32'h10);
        @(negedge clk);
        chk("t5_irq", {31'd0, cpu_irq}, 32'd1);
        chk("t5_id", {29'd0, cpu_irq_id}, 32'd4);

        // Asynchronous reset during service
        rest = 1'b1;
        #1;
        chk("t6_async_drop", {31'd0, cpu_irq}, 32'd0);
        irq_in = 8'h00;
        @(negedge clk); @(negedge clk);
        rest = 1'b0;
        @(negedge clk);
        bus_rd(4'd1, v); chk("t6_mask_reset", v, 32'd0);
        bus_rd(4'd4, v); chk("t6_vec_reset", v, 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
